// File: rtl/ldst_sequencer_if.sv
// -----------------------------------------------------------------------------
// ldst_sequencer_if
// Purpose : groups the sequencer's handshake inputs (start/run/opcode/mem_ready)
//           and the DataPath control/status outputs into one bundle.
// Modports: slave  - the sequencer (drives controls, reads handshake)
//           master - whoever drives start/run/opcode/mem_ready and consumes
//                    the control lines (DataPath glue or a testbench)
// Optional: SINGLE_STEP_EN adds the 1-bit step input to both modports.
// -----------------------------------------------------------------------------
interface ldst_sequencer_if #(
    parameter int OP_W = 5
);
    logic            start;
    logic            run;
    logic [OP_W-1:0] opcode;
    logic            mem_ready;
`ifdef SINGLE_STEP_EN
    logic            step;
`endif
    logic PCout, PCin, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
    logic Gra, Grb, Rin, Rout, BAout, Cout, Read, Write;
    logic [OP_W-1:0] Operator;
    logic            busy;
    logic            done;
    logic [1:0]      err;

`ifdef SINGLE_STEP_EN
    modport slave (
        input  start, run, opcode, mem_ready, step,
        output PCout, PCin, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
        output Gra, Grb, Rin, Rout, BAout, Cout, Read, Write,
        output Operator, busy, done, err
    );
    modport master (
        output start, run, opcode, mem_ready, step,
        input  PCout, PCin, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
        input  Gra, Grb, Rin, Rout, BAout, Cout, Read, Write,
        input  Operator, busy, done, err
    );
`else
    modport slave (
        input  start, run, opcode, mem_ready,
        output PCout, PCin, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
        output Gra, Grb, Rin, Rout, BAout, Cout, Read, Write,
        output Operator, busy, done, err
    );
    modport master (
        output start, run, opcode, mem_ready,
        input  PCout, PCin, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
        input  Gra, Grb, Rin, Rout, BAout, Cout, Read, Write,
        input  Operator, busy, done, err
    );
`endif
endinterface

// File: rtl/ldst_sequencer.sv
// -----------------------------------------------------------------------------
// ldst_sequencer
// Purpose : control-step sequencer for instruction fetch plus ld / ldi / st.
//           Drives the DataPath register/bus/memory controls one T-step per
//           cycle, stretches memory steps with a mem_ready handshake and a
//           timeout, and optionally chains instructions while run=1.
// Ports   : i_clk   - rising-edge clock
//           i_clear - asynchronous active-low reset
//           bus     - ldst_sequencer_if.slave: start, run, opcode, mem_ready
//                     in; DataPath controls, Operator, busy, done, err out
// Options : SINGLE_STEP_EN - adds bus.step; non-IDLE, non-wait states only
//           advance on a cycle with step=1. Undefined: advance every cycle.
// -----------------------------------------------------------------------------
module ldst_sequencer #(
    parameter int              IR_W    = 32,
    parameter int              OP_W    = 5,
    parameter logic [OP_W-1:0] OP_LD   = 5'b00000,
    parameter logic [OP_W-1:0] OP_LDI  = 5'b00001,
    parameter logic [OP_W-1:0] OP_ST   = 5'b00010,
    parameter logic [OP_W-1:0] ALU_ADD = 5'b00011,
    parameter int              MEM_TMO = 15
) (
    input  logic            i_clk,
    input  logic            i_clear,
    ldst_sequencer_if.slave bus
);

    if (IR_W < OP_W || MEM_TMO < 1) begin : g_bad_cfg
        $error("ldst_sequencer: opcode wider than IR or MEM_TMO < 1");
    end

    localparam int CNT_W = $clog2(MEM_TMO + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TMO - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T6W, S_T7, S_DONE
    } state_t;

    typedef enum logic [1:0] {K_LD, K_LDI, K_ST, K_BAD} kind_t;

    typedef struct packed {
        logic PCout, PCin, incPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout;
        logic Gra, Grb, Rin, Rout, BAout, Cout, Read, Write;
    } ctl_t;

    state_t          r_state, w_next;
    kind_t           r_kind, w_kind_nxt, w_kind_dec;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]      r_err, w_err_nxt;
    ctl_t            r_ctl, w_ctl;
    logic [OP_W-1:0] r_op, w_op;
    logic            r_busy, r_done;
    logic            w_adv, w_wait;

    always_comb begin
        if (bus.opcode == OP_LD)       w_kind_dec = K_LD;
        else if (bus.opcode == OP_LDI) w_kind_dec = K_LDI;
        else if (bus.opcode == OP_ST)  w_kind_dec = K_ST;
        else                           w_kind_dec = K_BAD;
    end

    // Next-state logic, then output decode of the state about to be occupied
    // so the registered outputs line up with the state register.
    always_comb begin
        w_next     = r_state;
        w_kind_nxt = r_kind;
        w_err_nxt  = r_err;
        w_cnt_nxt  = '0;
        w_wait     = (r_state == S_T1W) || (r_state == S_T6W);
`ifdef SINGLE_STEP_EN
        w_adv      = bus.step;
`else
        w_adv      = 1'b1;
`endif
        if (w_adv || w_wait || r_state == S_IDLE) begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    w_next    = S_T0;
                    w_err_nxt = 2'b00;
                end
                S_T0: w_next = S_T1;
                S_T1: w_next = S_T1W;
                S_T1W, S_T6W: begin
                    if (bus.mem_ready) begin
                        if (r_state == S_T1W)   w_next = S_T2;
                        else if (r_kind == K_ST) w_next = S_DONE;
                        else                     w_next = S_T7;
                    end else if (r_cnt == TMO_LAST) begin
                        // Timeout: abandon the access without a done pulse.
                        w_next    = S_IDLE;
                        w_err_nxt = 2'b10;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_T2: w_next = S_T3;
                S_T3: begin
                    w_kind_nxt = w_kind_dec;
                    if (w_kind_dec == K_BAD) begin
                        w_next    = S_IDLE;
                        w_err_nxt = 2'b01;
                    end else begin
                        w_next = S_T4;
                    end
                end
                S_T4: w_next = S_T5;
                S_T5: begin
                    case (r_kind)
                        K_LDI:   w_next = S_DONE;
                        K_ST:    w_next = S_T6;
                        default: w_next = S_T6W;
                    endcase
                end
                S_T6:   w_next = S_T6W;
                S_T7:   w_next = S_DONE;
                S_DONE: w_next = bus.run ? S_T0 : S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end

        w_ctl = '0;
        w_op  = '0;
        case (w_next)
            S_T0: begin
                w_ctl.PCout = 1'b1; w_ctl.MARin = 1'b1; w_ctl.incPC = 1'b1; w_ctl.Zin = 1'b1;
            end
            S_T1: begin
                w_ctl.Zlowout = 1'b1; w_ctl.PCin = 1'b1;
            end
            S_T1W: begin
                w_ctl.Read = 1'b1; w_ctl.MDRin = 1'b1;
            end
            S_T2: begin
                w_ctl.MDRout = 1'b1; w_ctl.IRin = 1'b1;
            end
            S_T3: begin
                w_ctl.Grb = 1'b1; w_ctl.BAout = 1'b1; w_ctl.Yin = 1'b1;
            end
            S_T4: begin
                w_ctl.Cout = 1'b1; w_ctl.Zin = 1'b1;
                w_op = ALU_ADD;
            end
            S_T5: begin
                w_ctl.Zlowout = 1'b1;
                if (w_kind_nxt == K_LDI) begin
                    w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1;
                end else begin
                    w_ctl.MARin = 1'b1;
                end
            end
            S_T6: begin
                // Register value is routed onto the bus into MDR (no memory read).
                w_ctl.Gra = 1'b1; w_ctl.Rout = 1'b1; w_ctl.MDRin = 1'b1;
            end
            S_T6W: begin
                if (w_kind_nxt == K_ST) begin
                    w_ctl.Write = 1'b1;
                end else begin
                    w_ctl.Read = 1'b1; w_ctl.MDRin = 1'b1;
                end
            end
            S_T7: begin
                w_ctl.MDRout = 1'b1; w_ctl.Gra = 1'b1; w_ctl.Rin = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_clear) begin
        if (!i_clear) begin
            r_state <= S_IDLE;
            r_kind  <= K_LD;
            r_cnt   <= '0;
            r_err   <= 2'b00;
            r_ctl   <= '0;
            r_op    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_kind  <= w_kind_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_ctl   <= w_ctl;
            r_op    <= w_op;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    assign bus.PCout    = r_ctl.PCout;
    assign bus.PCin     = r_ctl.PCin;
    assign bus.incPC    = r_ctl.incPC;
    assign bus.MARin    = r_ctl.MARin;
    assign bus.MDRin    = r_ctl.MDRin;
    assign bus.MDRout   = r_ctl.MDRout;
    assign bus.IRin     = r_ctl.IRin;
    assign bus.Yin      = r_ctl.Yin;
    assign bus.Zin      = r_ctl.Zin;
    assign bus.Zlowout  = r_ctl.Zlowout;
    assign bus.Gra      = r_ctl.Gra;
    assign bus.Grb      = r_ctl.Grb;
    assign bus.Rin      = r_ctl.Rin;
    assign bus.Rout     = r_ctl.Rout;
    assign bus.BAout    = r_ctl.BAout;
    assign bus.Cout     = r_ctl.Cout;
    assign bus.Read     = r_ctl.Read;
    assign bus.Write    = r_ctl.Write;
    assign bus.Operator = r_op;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule
